fwftn_reader: RTL

//  Converts a standard (read-latency 1) fifo into a first-word fall-through fifo whose

---
 rtl/fwftn_reader_pkg.sv | 11 +
 rtl/fwftn_buf.sv | 81 ++++++++
 rtl/fwftn_reader.sv | 98 +++++++++
 3 files changed

// File: rtl/fwftn_reader_pkg.sv
// Shared sizing for the N:1 fall-through reader family.
package fwftn_reader_pkg;

    localparam int unsigned LEVEL_W = 4;

    // Two full output words of headroom plus the single word that may be in flight.
    function automatic int unsigned fwft_cap(input int unsigned ratio);
        return 2 * ratio + 1;
    endfunction

endpackage

// File: rtl/fwftn_buf.sv
// Word shift buffer: entry 0 oldest, pops remove RATIO words, pushes append one word.
module fwftn_buf
    import fwftn_reader_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned RATIO = 2,
    parameter int unsigned CAP   = fwft_cap(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         din,
    output logic [LEVEL_W-1:0]   count,
    output logic [CAP*W-1:0]     entries
);

    localparam logic [LEVEL_W-1:0] RATIO_L = LEVEL_W'(RATIO);

    logic [W-1:0]       mem     [CAP];
    logic [W-1:0]       mem_nxt [CAP];
    logic [LEVEL_W-1:0] count_q;
    logic [LEVEL_W-1:0] count_nxt;
    logic [LEVEL_W-1:0] base;

    always_comb begin
        base = pop ? count_q - RATIO_L : count_q;
        for (int unsigned i = 0; i < CAP; i++) begin
            mem_nxt[i] = mem[i];
        end
        if (pop) begin
            for (int unsigned i = 0; i < CAP - RATIO; i++) begin
                mem_nxt[i] = mem[i + RATIO];
            end
            for (int unsigned i = CAP - RATIO; i < CAP; i++) begin
                mem_nxt[i] = '0;
            end
        end
        // The write lands after the pop shift, so a simultaneous pop+push is seamless.
        if (push) begin
            for (int unsigned i = 0; i < CAP; i++) begin
                if (LEVEL_W'(i) == base) begin
                    mem_nxt[i] = din;
                end
            end
        end
        count_nxt = base + LEVEL_W'(push);
        if (clear) begin
            for (int unsigned i = 0; i < CAP; i++) begin
                mem_nxt[i] = '0;
            end
            count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < CAP; i++) begin
                mem[i] <= '0;
            end
            count_q <= '0;
        end else if (clk_en) begin
            for (int unsigned i = 0; i < CAP; i++) begin
                mem[i] <= mem_nxt[i];
            end
            count_q <= count_nxt;
        end
    end

    always_comb begin
        entries = '0;
        for (int unsigned i = 0; i < CAP; i++) begin
            entries[i*W +: W] = mem[i];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fwftn_reader.sv
// Standard-fifo to first-word-fall-through adapter presenting RATIO words per output beat.
module fwftn_reader
    import fwftn_reader_pkg::*;
#(
    parameter int unsigned dta_width = 8,
    parameter int unsigned RATIO     = 2,
    parameter int unsigned MSW_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         flush,
    output logic                         fifo_rd_en,
    input  logic                         fifo_valid,
    input  logic [dta_width-1:0]         fifo_dout,
    output logic                         valid,
    output logic [RATIO*dta_width-1:0]   dout,
    input  logic                         rd_en,
    output logic [LEVEL_W-1:0]           level,
    output logic                         overflow
);

    localparam int unsigned        CAP     = fwft_cap(RATIO);
    localparam logic [LEVEL_W-1:0] RATIO_L = LEVEL_W'(RATIO);
    localparam logic [LEVEL_W-1:0] CAP_L   = LEVEL_W'(CAP);
    localparam logic [LEVEL_W-1:0] HIGH_L  = LEVEL_W'(2 * RATIO);

    logic [LEVEL_W-1:0]       count;
    logic [LEVEL_W-1:0]       avail;
    logic [LEVEL_W-1:0]       next_count;
    logic [CAP*dta_width-1:0] entries;
    logic                     pop;
    logic                     push_req;
    logic                     push;
    logic                     drop;
    logic                     drop_pend;

    assign valid = (count >= RATIO_L);
    assign level = count;

    always_comb begin
        pop        = rd_en & valid & ~flush;
        push_req   = fifo_valid & ~flush & ~drop_pend;
        avail      = pop ? count - RATIO_L : count;
        drop       = push_req & (avail == CAP_L);
        push       = push_req & ~drop;
        next_count = avail + LEVEL_W'(push);
    end

    fwftn_buf #(
        .W     (dta_width),
        .RATIO (RATIO),
        .CAP   (CAP)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .clear   (flush),
        .push    (push),
        .pop     (pop),
        .din     (fifo_dout),
        .count   (count),
        .entries (entries)
    );

    // drop_pend swallows the one word already requested when flush was taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_rd_en <= 1'b0;
            drop_pend  <= 1'b0;
            overflow   <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                fifo_rd_en <= 1'b0;
                drop_pend  <= 1'b1;
                overflow   <= 1'b0;
            end else begin
                fifo_rd_en <= (next_count < HIGH_L);
                drop_pend  <= 1'b0;
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (MSW_FIRST != 0) begin
                dout[(RATIO-1-i)*dta_width +: dta_width] = entries[i*dta_width +: dta_width];
            end else begin
                dout[i*dta_width +: dta_width] = entries[i*dta_width +: dta_width];
            end
        end
    end

endmodule
